jogador_automatico: RTL and testbench

Autonomous player for the memory-game datapath/controller (`circuito_exp7`). The block drives the game's `jogar` and `botoes` inputs, watches its `leds`, `pronto`, `ganhou` and `perdeu` outputs, and stores each newly shown LED in an internal 16-entry sequence memory. After each display it replays the whole stored sequence as timed button presses. It sits on the FPGA top level between the game and the physical buttons (muxed by `ativo`) for unattended board self-test.

---
 rtl/jogador_automatico_pkg.sv | 33 +++
 rtl/jogador_automatico_memoria_sequencia.sv | 24 ++
 rtl/jogador_automatico.sv | 182 ++++++++++++++++++
 tb/tb_jogador_automatico.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jogador_automatico_pkg.sv
// Shared types and constants for the autonomous memory-game player.
package jogador_automatico_pkg;

    localparam int DEPTH   = 16;
    localparam int ENTRY_W = 4;
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int SIZE_W  = $clog2(DEPTH + 1);

    typedef enum logic [3:0] {
        ST_IDLE          = 4'd0,
        ST_PARTIDA       = 4'd1,
        ST_ESPERA_LED    = 4'd2,
        ST_ESPERA_APAGA  = 4'd3,
        ST_ESPERA_QUIETO = 4'd4,
        ST_PRESSIONA     = 4'd5,
        ST_SOLTA         = 4'd6,
        ST_FIM           = 4'd7
    } estado_t;

    localparam logic [1:0] RES_NENHUM = 2'b00;
    localparam logic [1:0] RES_GANHOU = 2'b01;
    localparam logic [1:0] RES_PERDEU = 2'b10;
    localparam logic [1:0] RES_ERRO   = 2'b11;

    function automatic logic is_onehot(input logic [ENTRY_W-1:0] v);
        return (v != '0) && ((v & (v - ENTRY_W'(1))) == '0);
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/jogador_automatico_memoria_sequencia.sv
// 16x4 register file holding the LED sequence captured from the game.
module memoria_sequencia
    import jogador_automatico_pkg::*;
(
    input  logic               clock,
    input  logic               we,
    input  logic [ADDR_W-1:0]  addr_w,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]  addr_r,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    // NOTE: storage has no reset; entries are only read below the valid count, so stale data is harmless.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr_w] <= wr_data;
        end
    end

    assign rd_data = mem[addr_r];

endmodule

// File: rtl/jogador_automatico.sv
// Autonomous player: watches the game LEDs, records each new one, and replays the sequence as timed presses.
module jogador_automatico
    import jogador_automatico_pkg::*;
#(
    parameter int PRESS_CYCLES = 5,
    parameter int GAP_CYCLES   = 510,
    parameter int QUIET_CYCLES = 16,
    parameter int JOGAR_CYCLES = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] leds,
    input  logic       pronto,
    input  logic       ganhou,
    input  logic       perdeu,
    output logic       jogar,
    output logic [3:0] botoes,
    output logic       ativo,
    output logic       erro,
    output logic [1:0] resultado,
    output logic [3:0] db_estado,
    output logic [4:0] db_tamanho
);

    localparam int CNT_MAX = max_of(max_of(PRESS_CYCLES, GAP_CYCLES),
                                    max_of(QUIET_CYCLES, JOGAR_CYCLES));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] JOGAR_LAST = CNT_W'(JOGAR_CYCLES - 1);
    // Quiet window counts from the first zero sample, so replay starts QUIET_CYCLES+1 edges later.
    localparam logic [CNT_W-1:0] QUIET_END  = CNT_W'(QUIET_CYCLES);

    estado_t            estado, estado_d;
    logic [CNT_W-1:0]   cnt_tempo, cnt_d;
    logic [ADDR_W-1:0]  idx, idx_d;
    logic [SIZE_W-1:0]  tamanho, tamanho_d;
    logic               erro_d;
    logic [1:0]         resultado_d;
    logic               iniciar_q;
    logic               we;
    logic [ENTRY_W-1:0] rd_data;
    logic               status_hit;

    memoria_sequencia u_memoria (
        .clock   (clock),
        .we      (we),
        .addr_w  (tamanho[ADDR_W-1:0]),
        .wr_data (leds),
        .addr_r  (idx_d),
        .rd_data (rd_data)
    );

    assign status_hit = (estado != ST_IDLE) && (estado != ST_FIM) && (perdeu || ganhou || pronto);

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        estado_d    = estado;
        cnt_d       = cnt_tempo + 1'b1;
        idx_d       = idx;
        tamanho_d   = tamanho;
        erro_d      = erro;
        resultado_d = resultado;
        we          = 1'b0;

        case (estado)
            ST_IDLE: begin
                cnt_d       = '0;
                tamanho_d   = '0;
                erro_d      = 1'b0;
                resultado_d = RES_NENHUM;
                if (iniciar) estado_d = ST_PARTIDA;
            end
            ST_PARTIDA: begin
                if (cnt_tempo == JOGAR_LAST) begin
                    cnt_d    = '0;
                    estado_d = ST_ESPERA_LED;
                end
            end
            ST_ESPERA_LED: begin
                cnt_d = '0;
                if (leds != '0) begin
                    if (!is_onehot(leds) || tamanho == SIZE_W'(DEPTH)) begin
                        erro_d   = 1'b1;
                        estado_d = ST_FIM;
                    end else begin
                        we        = 1'b1;
                        tamanho_d = tamanho + 1'b1;
                        estado_d  = ST_ESPERA_APAGA;
                    end
                end
            end
            ST_ESPERA_APAGA: begin
                cnt_d = '0;
                if (leds == '0) estado_d = ST_ESPERA_QUIETO;
            end
            ST_ESPERA_QUIETO: begin
                // A returning LED is the same display flickering, not a new entry.
                if (leds != '0) begin
                    cnt_d    = '0;
                    estado_d = ST_ESPERA_APAGA;
                end else if (cnt_tempo == QUIET_END) begin
                    cnt_d    = '0;
                    idx_d    = '0;
                    estado_d = ST_PRESSIONA;
                end
            end
            ST_PRESSIONA: begin
                if (cnt_tempo == PRESS_LAST) begin
                    cnt_d    = '0;
                    estado_d = ST_SOLTA;
                end
            end
            ST_SOLTA: begin
                if (cnt_tempo == GAP_LAST) begin
                    cnt_d = '0;
                    if (({1'b0, idx} + 1'b1) < tamanho) begin
                        idx_d    = idx + 1'b1;
                        estado_d = ST_PRESSIONA;
                    end else begin
                        estado_d = ST_ESPERA_LED;
                    end
                end
            end
            ST_FIM: begin
                cnt_d = '0;
                if (iniciar && !iniciar_q) estado_d = ST_IDLE;
            end
            default: begin
                cnt_d    = '0;
                estado_d = ST_IDLE;
            end
        endcase

        // Game status overrides any capture or replay step in the same cycle.
        if (status_hit) begin
            we        = 1'b0;
            tamanho_d = tamanho;
            erro_d    = erro;
            cnt_d     = '0;
            estado_d  = ST_FIM;
            if (perdeu)      resultado_d = RES_PERDEU;
            else if (ganhou) resultado_d = RES_GANHOU;
        end

        if (erro_d) resultado_d = RES_ERRO;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado     <= ST_IDLE;
            cnt_tempo  <= '0;
            idx        <= '0;
            tamanho    <= '0;
            erro       <= 1'b0;
            resultado  <= RES_NENHUM;
            iniciar_q  <= 1'b0;
            jogar      <= 1'b0;
            botoes     <= '0;
            ativo      <= 1'b0;
            db_tamanho <= '0;
        end else begin
            estado     <= estado_d;
            cnt_tempo  <= cnt_d;
            idx        <= idx_d;
            tamanho    <= tamanho_d;
            erro       <= erro_d;
            resultado  <= resultado_d;
            iniciar_q  <= iniciar;
            jogar      <= (estado_d == ST_PARTIDA);
            botoes     <= (estado_d == ST_PRESSIONA) ? rd_data : '0;
            ativo      <= (estado_d != ST_IDLE) && (estado_d != ST_FIM);
            db_tamanho <= tamanho;
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_jogador_automatico.sv
// Scoreboard bench: stimulus predicts every replay press, a negedge monitor checks what the player does.
module tb_jogador_automatico;

    localparam int PRESS = 5;
    localparam int GAP   = 510;
    localparam int QUIET = 16;
    localparam int JOGAR = 5;
    localparam int SLOT  = PRESS + GAP;

    logic       clock = 1'b0;
    logic       reset, iniciar, pronto, ganhou, perdeu;
    logic [3:0] leds;
    logic       jogar, ativo, erro;
    logic [3:0] botoes, db_estado;
    logic [1:0] resultado;
    logic [4:0] db_tamanho;

    jogador_automatico dut (
        .clock      (clock),
        .reset      (reset),
        .iniciar    (iniciar),
        .leds       (leds),
        .pronto     (pronto),
        .ganhou     (ganhou),
        .perdeu     (perdeu),
        .jogar      (jogar),
        .botoes     (botoes),
        .ativo      (ativo),
        .erro       (erro),
        .resultado  (resultado),
        .db_estado  (db_estado),
        .db_tamanho (db_tamanho)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] val;
        int         start;
    } press_t;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    press_t     exp_q[$];
    logic [3:0] shown[$];
    bit         cut = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every rising press is popped from the scoreboard; widths and one-hot stability are checked.
    logic [3:0] prev_b = 4'd0;
    int         width  = 0;
    press_t     got;

    always @(negedge clock) begin
        if (botoes != 4'd0 && prev_b == 4'd0) begin
            width = 1;
            if (exp_q.size() == 0) begin
                check("unexpected_press", int'(botoes), 0);
            end else begin
                got = exp_q.pop_front();
                check("press_value", int'(botoes), int'(got.val));
                check("press_start", cyc, got.start);
            end
        end else if (botoes != 4'd0) begin
            width++;
            if (botoes != prev_b) check("press_changed", int'(botoes), int'(prev_b));
        end else if (prev_b != 4'd0 && !cut) begin
            check("press_width", width, PRESS);
        end
        prev_b = botoes;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_state(input int code, input int budget, input string name);
        int i = 0;
        while (db_estado != 4'(code) && i < budget) begin
            tick(1);
            i++;
        end
        check(name, int'(db_estado), code);
    endtask

    function automatic logic [3:0] rand_led();
        logic [3:0] one = 4'b0001;
        return one << $urandom_range(0, 3);
    endfunction

    task automatic start_game();
        int i = 0;
        int w = 0;
        iniciar = 1'b0;
        tick(2);
        iniciar = 1'b1;
        while (!jogar && i < 10) begin
            tick(1);
            i++;
        end
        check("ativo_partida", int'(ativo), 1);
        while (jogar && w < 20) begin
            tick(1);
            w++;
        end
        check("jogar_width", w, JOGAR);
        iniciar = 1'b0;
        shown.delete();
        cut = 1'b0;
        wait_state(2, 5, "reach_espera_led");
        check("tamanho_cleared", int'(db_tamanho), 0);
    endtask

    // Show one LED; the reference model replays the whole stored list from the final zero sample.
    task automatic show_round(input logic [3:0] led, input int dur, input bit flicker);
        int c;
        leds = led;
        tick(dur);
        if (flicker) begin
            leds = 4'd0;
            tick($urandom_range(2, 10));
            leds = led;
            tick(4);
        end
        leds = 4'd0;
        c = cyc;
        shown.push_back(led);
        foreach (shown[j]) begin
            press_t e;
            e.val   = shown[j];
            e.start = c + 1 + QUIET + 1 + j * SLOT;
            exp_q.push_back(e);
        end
        tick(3);
        check("db_tamanho", int'(db_tamanho), shown.size());
    endtask

    task automatic wait_replay(input string name);
        int i = 0;
        int budget = shown.size() * SLOT + QUIET + 100;
        while (!(exp_q.size() == 0 && db_estado == 4'd2) && i < budget) begin
            tick(1);
            i++;
        end
        check(name, int'(db_estado), 2);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; iniciar = 1'b0; leds = 4'd0;
        pronto = 1'b0; ganhou = 1'b0; perdeu = 1'b0;
        tick(3);
        check("rst_jogar", int'(jogar), 0);
        check("rst_botoes", int'(botoes), 0);
        check("rst_ativo", int'(ativo), 0);
        check("rst_erro", int'(erro), 0);
        check("rst_resultado", int'(resultado), 0);
        check("rst_estado", int'(db_estado), 0);
        check("rst_tamanho", int'(db_tamanho), 0);
        reset = 1'b0;
        tick(2);

        // Growing sequence: replays of length 1, 2, 3.
        start_game();
        show_round(4'b0001, 2000, 1'b0);
        wait_replay("replay1");
        show_round(4'b0010, $urandom_range(3, 30), 1'b1);
        wait_replay("replay2");
        show_round(4'b0100, $urandom_range(3, 30), 1'b0);
        wait_replay("replay3");

        // ganhou together with pronto during the gap.
        show_round(rand_led(), 5, 1'b0);
        wait_state(6, 200, "reach_solta");
        ganhou = 1'b1; pronto = 1'b1;
        tick(1);
        check("win_botoes", int'(botoes), 0);
        check("win_estado", int'(db_estado), 7);
        check("win_resultado", int'(resultado), 1);
        check("win_ativo", int'(ativo), 0);
        exp_q.delete();
        ganhou = 1'b0; pronto = 1'b0;
        tick(3);

        // perdeu in the middle of a press.
        start_game();
        show_round(rand_led(), 4, 1'b0);
        wait_state(5, 100, "reach_pressiona");
        tick(2);
        cut = 1'b1;
        perdeu = 1'b1;
        tick(1);
        check("lose_botoes", int'(botoes), 0);
        check("lose_estado", int'(db_estado), 7);
        check("lose_resultado", int'(resultado), 2);
        exp_q.delete();
        perdeu = 1'b0;
        tick(3);

        // Non-one-hot LED.
        start_game();
        leds = 4'b0011;
        tick(1);
        leds = 4'd0;
        tick(1);
        check("bad_led_erro", int'(erro), 1);
        check("bad_led_resultado", int'(resultado), 3);
        check("bad_led_estado", int'(db_estado), 7);
        check("bad_led_botoes", int'(botoes), 0);

        // Sixteen captures, then overflow.
        start_game();
        for (int k = 0; k < 16; k++) begin
            show_round(rand_led(), 3, 1'b0);
            wait_replay("replay_fill");
        end
        leds = rand_led();
        tick(3);
        leds = 4'd0;
        tick(1);
        check("ovf_tamanho", int'(db_tamanho), 16);
        check("ovf_erro", int'(erro), 1);
        check("ovf_estado", int'(db_estado), 7);
        check("ovf_resultado", int'(resultado), 3);

        // Asynchronous reset in the middle of a press.
        start_game();
        show_round(rand_led(), 4, 1'b0);
        wait_state(5, 100, "reach_pressiona_rst");
        cut = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("async_rst_botoes", int'(botoes), 0);
        check("async_rst_jogar", int'(jogar), 0);
        check("async_rst_estado", int'(db_estado), 0);
        check("async_rst_tamanho", int'(db_tamanho), 0);
        exp_q.delete();
        tick(2);
        reset = 1'b0;
        tick(2);
        check("post_rst_estado", int'(db_estado), 0);

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
